// File: rtl/wb_pkg.sv
// Shared Wishbone types and defaults for the two-master arbiter.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package wb_pkg;

    localparam int ADR_W_DEF = 15;
    localparam int DAT_W_DEF = 16;
    localparam int SEL_W_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2,
        ERR  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic                 cyc;
        logic                 stb;
        logic                 we;
        logic [SEL_W_DEF-1:0] sel;
        logic [ADR_W_DEF-1:0] adr;
        logic [DAT_W_DEF-1:0] dat;
    } wb_req_t;

    typedef struct packed {
        logic                 ack;
        logic                 err;
        logic [DAT_W_DEF-1:0] dat;
    } wb_rsp_t;

    // One-hot owner vector presented on grant_o for a given arbiter state.
    function automatic logic [1:0] grant_of(arb_state_t s);
        case (s)
            GNT0:    return 2'b01;
            GNT1:    return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Ack watchdog: counts strobed cycles without ack and flags the cycle that reaches the limit.
// Latency: fire is combinational from the registered count (asserted in the TIMEOUT-th waiting cycle).
// Backpressure: none; a same-cycle ack always suppresses fire. TIMEOUT = 0 disables it.
module wb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en,
    input  logic ack,
    input  logic clear,
    output logic fire
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] wd_cnt;

    // Count consecutive waiting cycles; any ack, idle strobe or ownership change restarts it.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear || ack || !en || (TIMEOUT == 0)) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + CW'(1);
        end
    end

    // Fire only while still waiting, so an ack landing on the limit cycle wins.
    always_comb begin
        fire = (TIMEOUT > 0) && en && !ack && (wd_cnt == LAST);
    end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter with cyc lock and per-transfer ack watchdog.
// Latency: one cycle from request in IDLE to slave cycle; zero-idle handoff between owners.
// Backpressure: the non-owner simply waits with cyc high; a hung owner is cut off with err.
module wb_arbiter2
    import wb_pkg::*;
#(
    parameter int ADR_W   = ADR_W_DEF,
    parameter int DAT_W   = DAT_W_DEF,
    parameter int SEL_W   = SEL_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic [SEL_W-1:0] m0_sel_i,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    output logic [DAT_W-1:0] m0_dat_o,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic [SEL_W-1:0] m1_sel_i,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic [DAT_W-1:0] m1_dat_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic [SEL_W-1:0] s_sel_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [DAT_W-1:0] s_dat_o,
    input  logic             s_ack_i,
    input  logic [DAT_W-1:0] s_dat_i,
    output logic [1:0]       grant_o
);

    typedef struct packed {
        logic             cyc;
        logic             stb;
        logic             we;
        logic [SEL_W-1:0] sel;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
    } req_t;

    arb_state_t state_q, state_d;
    logic       last_owner_q;   // 0 = m0, 1 = m1; also identifies the faulted master in ERR
    req_t       m0_req, m1_req, own_req, slv_req;
    logic       wd_fire, wd_clr;

    assign m0_req = {m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i};
    assign m1_req = {m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i};

    // State and last-owner registers; last_owner updates on entry to a grant state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_d == GNT0 && state_q != GNT0) begin
                last_owner_q <= 1'b0;
            end else if (state_d == GNT1 && state_q != GNT1) begin
                last_owner_q <= 1'b1;
            end
        end
    end

    // Next-state: round-robin ties, cyc lock, zero-idle handoff, single-cycle ERR.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_owner_q ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_d = GNT0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    state_d = m1_cyc_i ? GNT1 : IDLE;
                end else if (wd_fire) begin
                    state_d = ERR;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    state_d = m0_cyc_i ? GNT0 : IDLE;
                end else if (wd_fire) begin
                    state_d = ERR;
                end
            end
            ERR: begin
                if (last_owner_q) begin
                    state_d = m0_cyc_i ? GNT0 : IDLE;
                end else begin
                    state_d = m1_cyc_i ? GNT1 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request mux: the owner's bus drives the slave; nothing is driven while idle, faulted or in reset.
    always_comb begin
        own_req = '0;
        case (state_q)
            GNT0:    own_req = m0_req;
            GNT1:    own_req = m1_req;
            default: own_req = '0;
        endcase
        slv_req = rst_i ? '0 : own_req;
    end

    assign wd_clr = (state_d != state_q);

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (own_req.stb),
        .ack   (s_ack_i),
        .clear (wd_clr),
        .fire  (wd_fire)
    );

    // Slave-side outputs and master terminations; reset blocks any late ack/err.
    always_comb begin
        s_cyc_o  = slv_req.cyc;
        s_stb_o  = slv_req.stb;
        s_we_o   = slv_req.we;
        s_sel_o  = slv_req.sel;
        s_adr_o  = slv_req.adr;
        s_dat_o  = slv_req.dat;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;
        m0_dat_o = '0;
        m1_dat_o = '0;
        if (!rst_i) begin
            m0_ack_o = (state_q == GNT0) && s_ack_i;
            m1_ack_o = (state_q == GNT1) && s_ack_i;
            m0_err_o = (state_q == ERR) && !last_owner_q;
            m1_err_o = (state_q == ERR) && last_owner_q;
            if (state_q == GNT0 || state_q == GNT1) begin
                m0_dat_o = s_dat_i;
                m1_dat_o = s_dat_i;
            end
        end
        grant_o = grant_of(state_q);
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
module tb_wb_arbiter2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mc_cyc [2];
    logic        mc_stb [2];
    logic        mc_we  [2];
    logic [1:0]  mc_sel [2];
    logic [14:0] mc_adr [2];
    logic [15:0] mc_dat [2];
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [15:0] m0_rdat, m1_rdat;
    logic        s_cyc, s_stb, s_we, s_ack;
    logic [1:0]  s_sel;
    logic [14:0] s_adr;
    logic [15:0] s_wdat, s_rdat;
    logic [1:0]  grant;

    logic [15:0] mem     [0:1023];
    logic [15:0] ref_mem [0:1023];
    logic        ack_en;

    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    logic [1:0]  g_trace [$];
    logic [1:0]  g_last = 2'b00;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_arbiter2 #(
        .ADR_W (15), .DAT_W (16), .SEL_W (2), .TIMEOUT (8)
    ) dut (
        .clk_i    (clk),        .rst_i    (rst),
        .m0_cyc_i (mc_cyc[0]),  .m0_stb_i (mc_stb[0]), .m0_we_i (mc_we[0]),
        .m0_sel_i (mc_sel[0]),  .m0_adr_i (mc_adr[0]), .m0_dat_i (mc_dat[0]),
        .m0_ack_o (m0_ack),     .m0_err_o (m0_err),    .m0_dat_o (m0_rdat),
        .m1_cyc_i (mc_cyc[1]),  .m1_stb_i (mc_stb[1]), .m1_we_i (mc_we[1]),
        .m1_sel_i (mc_sel[1]),  .m1_adr_i (mc_adr[1]), .m1_dat_i (mc_dat[1]),
        .m1_ack_o (m1_ack),     .m1_err_o (m1_err),    .m1_dat_o (m1_rdat),
        .s_cyc_o  (s_cyc),      .s_stb_o  (s_stb),     .s_we_o   (s_we),
        .s_sel_o  (s_sel),      .s_adr_o  (s_adr),     .s_dat_o  (s_wdat),
        .s_ack_i  (s_ack),      .s_dat_i  (s_rdat),
        .grant_o  (grant)
    );

    // Memory slave: registered single-beat ack, write committed on the acking edge.
    assign s_rdat = mem[s_adr[9:0]];
    always @(posedge clk) begin
        if (rst) begin
            s_ack    <= 1'b0;
            mem[16]  <= 16'hBEEF;
        end else begin
            s_ack <= ack_en && s_cyc && s_stb && !s_ack;
            if (ack_en && s_cyc && s_stb && s_we && !s_ack)
                mem[s_adr[9:0]] <= s_wdat;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Read-data scoreboard and grant trace, sampled on the falling edge.
    always @(negedge clk) begin
        if (m0_ack && !mc_we[0]) begin
            if (q0.size() == 0) chk("sb0_unexpected_ack", 32'd1, 32'd0);
            else                chk("rd0_data", {16'd0, m0_rdat}, {16'd0, q0.pop_front()});
        end
        if (m1_ack && !mc_we[1]) begin
            if (q1.size() == 0) chk("sb1_unexpected_ack", 32'd1, 32'd0);
            else                chk("rd1_data", {16'd0, m1_rdat}, {16'd0, q1.pop_front()});
        end
        if (grant != g_last) begin
            g_trace.push_back(grant);
            g_last <= grant;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One single-beat transfer for master m; keep holds cyc for a following beat.
    task automatic xfer(input int m, input logic we, input logic [14:0] adr,
                        input logic [15:0] dat, input bit keep);
        bit got = 1'b0;
        mc_cyc[m] = 1'b1; mc_stb[m] = 1'b1; mc_we[m] = we;
        mc_sel[m] = 2'b11; mc_adr[m] = adr; mc_dat[m] = dat;
        if (we) ref_mem[adr[9:0]] = dat;
        else if (m == 0) q0.push_back(ref_mem[adr[9:0]]);
        else q1.push_back(ref_mem[adr[9:0]]);
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            got = (m == 0) ? m0_ack : m1_ack;
        end
        chk($sformatf("ack_seen_m%0d", m), {31'd0, got}, 32'd1);
        @(posedge clk);
        #1;
        mc_stb[m] = 1'b0;
        if (!keep) mc_cyc[m] = 1'b0;
    endtask

    // Element i of exp (2 bits each, element 0 in the LSBs) is the i-th grant change.
    task automatic check_trace(input string tag, input logic [9:0] exp, input int n);
        chk({tag, "_len"}, g_trace.size(), n);
        for (int i = 0; i < n; i++)
            if (i < g_trace.size())
                chk($sformatf("%s_%0d", tag, i), {30'd0, g_trace[i]}, {30'd0, exp[2*i +: 2]});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        rst    = 1'b1;
        ack_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mc_cyc[i] = 0; mc_stb[i] = 0; mc_we[i] = 0;
            mc_sel[i] = 0; mc_adr[i] = 0; mc_dat[i] = 0;
        end
        for (int i = 0; i < 1024; i++) ref_mem[i] = 16'h0;
        ref_mem[16] = 16'hBEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_s_cyc", {31'd0, s_cyc}, 32'd0);
        chk("rst_s_stb", {31'd0, s_stb}, 32'd0);
        chk("rst_acks",  {30'd0, m0_ack, m1_ack}, 32'd0);
        chk("rst_errs",  {30'd0, m0_err, m1_err}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single master read with grant latency.
        fork
            xfer(0, 1'b0, 15'h0010, 16'h0, 1'b0);
            begin
                @(negedge clk); chk("lat_idle_grant", {30'd0, grant}, 32'd0);
                @(negedge clk); chk("lat_grant01", {30'd0, grant}, 32'd1);
                                chk("lat_s_cyc", {31'd0, s_cyc}, 32'd1);
                @(negedge clk); chk("single_m0_ack", {31'd0, m0_ack}, 32'd1);
                                chk("single_m1_ack", {31'd0, m1_ack}, 32'd0);
            end
        join
        tick();

        // Tie after reset: m0 first, then zero-idle handoff to m1.
        do_reset();
        tick();
        g_trace.delete();
        fork
            xfer(0, 1'b0, 15'h0010, 16'h0, 1'b0);
            xfer(1, 1'b0, 15'h0010, 16'h0, 1'b0);
        join
        tick(); tick();
        check_trace("tie", {4'b0, 2'b00, 2'b10, 2'b01}, 3);

        // Round-robin: both keep requesting, one transfer per ownership.
        g_trace.delete();
        fork
            begin repeat (2) begin xfer(0, 1'b0, 15'h0010, 16'h0, 1'b0); tick(); end end
            begin repeat (2) begin xfer(1, 1'b0, 15'h0010, 16'h0, 1'b0); tick(); end end
        join
        tick(); tick();
        check_trace("rr", {2'b00, 2'b10, 2'b01, 2'b10, 2'b01}, 5);

        // Lock: m0 burst of 4 writes under one cyc while m1 waits.
        g_trace.delete();
        fork
            begin
                for (int i = 0; i < 4; i++)
                    xfer(0, 1'b1, 15'h0100 + 15'(i), 16'hA000 + 16'(i), i < 3);
            end
            begin tick(); xfer(1, 1'b0, 15'h0010, 16'h0, 1'b0); end
        join
        tick(); tick();
        check_trace("lock", {4'b0, 2'b00, 2'b10, 2'b01}, 3);
        for (int i = 0; i < 4; i++)
            chk($sformatf("lock_mem_%0d", i), {16'd0, mem[256 + i]}, {16'd0, 16'hA000 + 16'(i)});
        for (int i = 0; i < 4; i++)
            xfer(0, 1'b0, 15'h0100 + 15'(i), 16'h0, i < 3);
        tick();

        // Watchdog: slave never acks m1; after 8 waiting cycles m1 gets err, then m0 is served.
        ack_en = 1'b0;
        mc_cyc[1] = 1'b1; mc_stb[1] = 1'b1; mc_we[1] = 1'b0; mc_adr[1] = 15'h0020;
        fork
            begin
                int  gcyc = 0;
                bit  seen = 1'b0;
                for (int i = 0; i < 40 && !seen; i++) begin
                    @(negedge clk);
                    if (m1_err) begin
                        seen = 1'b1;
                        chk("wd_wait_cycles", gcyc, 32'd8);
                        chk("wd_s_cyc", {31'd0, s_cyc}, 32'd0);
                        chk("wd_grant", {30'd0, grant}, 32'd0);
                        chk("wd_m0_err", {31'd0, m0_err}, 32'd0);
                        mc_cyc[1] = 1'b0; mc_stb[1] = 1'b0;
                        ack_en = 1'b1;
                    end else if (grant == 2'b10) begin
                        gcyc++;
                    end
                end
                chk("wd_err_seen", {31'd0, seen}, 32'd1);
                @(negedge clk);
                chk("wd_err_pulse", {31'd0, m1_err}, 32'd0);
                chk("wd_then_m0", {30'd0, grant}, 32'd1);
            end
            begin tick(); tick(); tick(); xfer(0, 1'b0, 15'h0010, 16'h0, 1'b0); end
        join
        tick();

        // Reset in the middle of an m1 write.
        mc_cyc[1] = 1'b1; mc_stb[1] = 1'b1; mc_we[1] = 1'b1;
        mc_adr[1] = 15'h0030; mc_dat[1] = 16'h1234;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_no_ack", {31'd0, m1_ack}, 32'd0);
        tick();
        @(negedge clk);
        chk("rstmid_grant", {30'd0, grant}, 32'd0);
        chk("rstmid_s_cyc", {31'd0, s_cyc}, 32'd0);
        chk("rstmid_s_stb", {31'd0, s_stb}, 32'd0);
        chk("rstmid_m1_err", {31'd0, m1_err}, 32'd0);
        mc_cyc[1] = 1'b0; mc_stb[1] = 1'b0; mc_we[1] = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        g_trace.delete();
        fork
            xfer(0, 1'b0, 15'h0010, 16'h0, 1'b0);
            xfer(1, 1'b0, 15'h0101, 16'h0, 1'b0);
        join
        tick(); tick();
        check_trace("post_rst_tie", {4'b0, 2'b00, 2'b10, 2'b01}, 3);

        chk("sb_drained", q0.size() + q1.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
